// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: one FSM state per cycle, with control strobes
// and mux selects decoded from the current state and the instruction fields.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_LINK = 4'd12,
        S_LUI       = 4'd13
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;

    state_t r_state;
    state_t w_next;
    logic   w_pc_write;
    logic   w_mem_write;
    logic   w_ir_write;
    logic   w_reg_write;

    // State register; reset drops straight back to FETCH without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_next      = S_FETCH;
        w_pc_write  = 1'b0;
        adr_src     = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_S: w_next = S_MEM_ADR;
                    OP_R:        w_next = S_EXEC_R;
                    OP_I:        w_next = S_EXEC_I;
                    OP_B:        w_next = S_BRANCH;
                    OP_JAL:      w_next = S_JAL;
                    OP_JALR:     w_next = S_JALR;
                    OP_LUI:      w_next = S_LUI;
                    default:     w_next = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
                w_next  = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                w_next    = S_ALU_WB;
                case (funct3)
                    3'd0:    alu_control = (funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
                    3'd6:    alu_control = ALU_OR;
                    3'd7:    alu_control = ALU_AND;
                    3'd2:    alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = S_ALU_WB;
                case (funct3)
                    3'd6:    alu_control = ALU_OR;
                    3'd7:    alu_control = ALU_AND;
                    3'd2:    alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                case (funct3)
                    3'd0:    w_pc_write = zero;
                    3'd1:    w_pc_write = ~zero;
                    default: w_pc_write = 1'b0;
                endcase
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_reg_write = 1'b1;
            end
            S_LUI: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_PASS;
                w_next      = S_ALU_WB;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Immediate format depends only on the opcode, whatever the state.
    always_comb begin
        case (op)
            OP_S:    imm_src = 3'b001;
            OP_B:    imm_src = 3'b010;
            OP_JAL:  imm_src = 3'b011;
            OP_LUI:  imm_src = 3'b100;
            default: imm_src = 3'b000;
        endcase
    end

    // State sits at FETCH during reset, so its strobes must be gated off explicitly.
    assign pc_write  = w_pc_write  & ~rst;
    assign ir_write  = w_ir_write  & ~rst;
    assign mem_write = w_mem_write & ~rst;
    assign reg_write = w_reg_write & ~rst;
    assign state     = r_state;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  instruction opcode, from the instruction register.
REQ-005 funct3  in  3  instruction funct3.
REQ-006 funct7  in  7  instruction funct7.
REQ-007 zero  in  1  ALU zero flag for the current cycle.
REQ-008 pc_write  out  1  PC load strobe.
REQ-009 adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_write  out  1  data memory write strobe.
REQ-011 ir_write  out  1  instruction-register and old_pc load strobe.
REQ-012 reg_write  out  1  register-file write strobe.
REQ-013 result_src  out  2  result mux select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
REQ-014 alu_src_a  out  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1.
REQ-015 alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
REQ-016 alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 pass-B.
REQ-017 imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-018 state  out  4  current FSM state encoding, for debug and verification.

Function
REQ-019 Opcodes SHALL be: R 0110011, I 0010011, LW 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
REQ-020 States and encodings SHALL be: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, JALR 11, JALR_LINK 12, LUI 13.
REQ-021 Any output not listed for a state SHALL be 0.
REQ-022 FETCH SHALL drive adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1, and go to DECODE.
REQ-023 DECODE SHALL drive a=01, b=01, add, so that ALUOut holds the branch/JAL target.
REQ-024 DECODE SHALL go to MEM_ADR for LW/S, EXEC_R for R, EXEC_I for I, BRANCH for B, JAL for JAL, JALR for JALR, and LUI for LUI.
REQ-025 DECODE SHALL go to FETCH for any other opcode (treated as a nop; PC was already advanced).
REQ-026 MEM_ADR SHALL drive a=10, b=01, add, then go to MEM_READ if op=LW, else MEM_WRITE.
REQ-027 MEM_READ SHALL drive adr_src=1, result_src=00, then go to MEM_WB.
REQ-028 MEM_WB SHALL drive result_src=01, reg_write=1, then go to FETCH.
REQ-029 MEM_WRITE SHALL drive adr_src=1, result_src=00, mem_write=1, then go to FETCH.
REQ-030 EXEC_R SHALL drive a=10, b=00 and go to ALU_WB; alu_control SHALL be:
- funct3 0 with funct7 0x00: add; funct3 0 with funct7 0x20: sub.
- funct3 6: or; funct3 7: and; funct3 2: slt.
- any other combination: add.
REQ-031 EXEC_I SHALL drive a=10, b=01 and go to ALU_WB; alu_control by funct3: 0 add, 6 or, 7 and, 2 slt, other add.
REQ-032 ALU_WB SHALL drive result_src=00, reg_write=1, then go to FETCH.
REQ-033 BRANCH SHALL drive a=10, b=00, sub, result_src=00, then go to FETCH.
REQ-034 In BRANCH, pc_write SHALL be: funct3 0 (beq) = zero; funct3 1 (bne) = !zero; otherwise 0. This is combinational on zero in the same cycle.
REQ-035 JAL SHALL drive a=01, b=10, add, result_src=00, pc_write=1, then go to ALU_WB (writes old_pc+4).
REQ-036 JALR SHALL drive a=10, b=01, add, result_src=10, pc_write=1, then go to JALR_LINK.
REQ-037 JALR_LINK SHALL drive a=01, b=10, add, result_src=10, reg_write=1, then go to FETCH.
REQ-038 LUI SHALL drive b=01, alu_control=110, then go to ALU_WB.
REQ-039 imm_src SHALL be decoded combinationally from op in every state:
- I/LW/JALR: 000; S: 001; B: 010; JAL: 011; LUI: 100; other: 000.
REQ-040 CPI SHALL be: LW 5; S, R, I, LUI, JAL 4; JALR 4; B 3.
REQ-041 State SHALL update only on the rising clk edge; op/funct changes mid-instruction SHALL affect only the combinational outputs.

Reset
REQ-042 Asserting rst SHALL set state to FETCH immediately, without waiting for clk, including mid-instruction.
REQ-043 While rst is high, pc_write, ir_write, mem_write and reg_write SHALL be forced to 0.
REQ-044 The first rising clk edge after rst deasserts SHALL execute FETCH.

Verification
REQ-045 The bench SHALL cover:
- LW: op=0000011 -> states 0,1,2,3,4,0; reg_write=1 and result_src=01 only in state 4.
- beq: op=1100011, funct3=0, zero=1 -> pc_write=1 in state 9; with zero=0 -> pc_write=0; then back to state 0.
- R sub: funct3=0, funct7=0x20 -> alu_control=001 in state 6; funct7=0x00 gives 000; funct3=2 gives 101.
- JALR -> states 0,1,11,12,0; pc_write in 11, reg_write in 12, never both in one cycle.
- Unknown op=0000000 -> states 0,1,0.
- rst asserted in state 3 -> state=0 before the next clk edge; strobes are 0 while rst is high.
